// File: rtl/sensor_spi_arbiter_pkg.sv
// rtl/sensor_spi_arbiter_pkg.sv - shared types and defaults for the sensor SPI arbiter
// Purpose: arbiter state encoding, clock-rate constant and parameter defaults.
// Ports: none (package).
package sensor_spi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam int CLK_HZ               = 3_000_000;
    // One second of bus hold at the system clock rate.
    localparam int DEF_TIMEOUT_CYCLES   = CLK_HZ;
    localparam int DEF_GAP_CYCLES       = 4;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin picker
// Purpose: choose which of two requesters is granted.
// Ports:
//   req[1:0]   in   active requests
//   last_grant in   index granted most recently
//   grant      out  chosen index (0 when nobody requests)
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            // Tie: hand the bus to whoever did not have it last.
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/sensor_spi_arbiter.sv
// rtl/sensor_spi_arbiter.sv - shares one spi_master between two sensor controllers
// Purpose: round-robin arbitration of a single SPI master with chip-select
//          framing, a release gap between grants and a hold timeout.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   r_start/r_tx_valid/r_cs_n [1:0]    per-requester controls
//   r_tx_data0, r_tx_data1 [7:0]       per-requester transmit bytes
//   r_tx_ready/r_rx_valid/r_busy [1:0] per-requester status returns
//   r_rx_data [7:0]                    shared receive byte
//   m_start, m_tx_valid, m_tx_data     to spi_master
//   m_tx_ready, m_rx_valid, m_busy,
//   m_rx_data                          from spi_master
//   cs_n [1:0]                         physical chip selects
//   grant_id, grant_active             current/last grant, high in GRANT
//   timeout_err                        sticky hold-timeout flag
module sensor_spi_arbiter
    import sensor_spi_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] r_start,
    input  logic [1:0] r_tx_valid,
    input  logic [7:0] r_tx_data0,
    input  logic [7:0] r_tx_data1,
    input  logic [1:0] r_cs_n,
    output logic [1:0] r_tx_ready,
    output logic [1:0] r_rx_valid,
    output logic [1:0] r_busy,
    output logic [7:0] r_rx_data,
    output logic       m_start,
    output logic       m_tx_valid,
    output logic [7:0] m_tx_data,
    input  logic       m_tx_ready,
    input  logic       m_rx_valid,
    input  logic       m_busy,
    input  logic [7:0] m_rx_data,
    output logic [1:0] cs_n,
    output logic       grant_id,
    output logic       grant_active,
    output logic       timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_MAX     = GW'(GAP_CYCLES);
    // The chip-select-high interval spans DRAIN, GAP and the IDLE
    // arbitration cycle; GAP is left once DRAIN+GAP have covered all but
    // the final IDLE cycle, so an immediate drain yields exactly GAP_CYCLES.
    localparam logic [GW-1:0] GAP_EXIT    = GW'((GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0);

    arb_state_t      state;
    logic            last_grant;
    logic [1:0]      blocked;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gap_cnt;
    logic [1:0]      req;
    logic            pick;
    logic [TW-1:0]   tcnt_inc;
    logic [GW-1:0]   gap_inc;

    assign req      = ~r_cs_n & ~blocked;
    assign tcnt_inc = (tcnt == TIMEOUT_MAX) ? tcnt : tcnt + TW'(1);
    assign gap_inc  = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + GW'(1);

    arb_rr2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cs_n         <= 2'b11;
            grant_active <= 1'b0;
            grant_id     <= 1'b0;
            last_grant   <= 1'b1;
            timeout_err  <= 1'b0;
            blocked      <= 2'b00;
            tcnt         <= '0;
            gap_cnt      <= '0;
        end else begin
            // A requester that lets go of its framing is eligible again;
            // a timeout below overrides this for the same cycle.
            for (int i = 0; i < 2; i++) begin
                if (r_cs_n[i]) begin
                    blocked[i] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state        <= ST_GRANT;
                        grant_id     <= pick;
                        last_grant   <= pick;
                        grant_active <= 1'b1;
                        cs_n         <= pick ? 2'b01 : 2'b10;
                        tcnt         <= '0;
                    end
                end
                ST_GRANT: begin
                    tcnt <= tcnt_inc;
                    // Timeout wins over a release seen in the same cycle.
                    if (tcnt_inc == TIMEOUT_MAX) begin
                        timeout_err       <= 1'b1;
                        blocked[grant_id] <= 1'b1;
                        state             <= ST_DRAIN;
                        cs_n              <= 2'b11;
                        grant_active      <= 1'b0;
                        gap_cnt           <= '0;
                    end else if (r_cs_n[grant_id]) begin
                        state        <= ST_DRAIN;
                        cs_n         <= 2'b11;
                        grant_active <= 1'b0;
                        gap_cnt      <= '0;
                    end
                end
                ST_DRAIN: begin
                    gap_cnt <= gap_inc;
                    if (!m_busy) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_inc;
                    if (gap_cnt >= GAP_EXIT) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pass-through only for the granted requester; everyone else sees a
    // busy, never-ready master and its strobes are dropped.
    always_comb begin
        m_start    = 1'b0;
        m_tx_valid = 1'b0;
        m_tx_data  = 8'h00;
        r_tx_ready = 2'b00;
        r_rx_valid = 2'b00;
        r_busy     = 2'b11;
        r_rx_data  = 8'h00;
        if (grant_active) begin
            m_start              = r_start[grant_id];
            m_tx_valid           = r_tx_valid[grant_id];
            m_tx_data            = grant_id ? r_tx_data1 : r_tx_data0;
            r_tx_ready[grant_id] = m_tx_ready;
            r_rx_valid[grant_id] = m_rx_valid;
            r_busy[grant_id]     = m_busy;
            r_rx_data            = m_rx_data;
        end
    end

endmodule

// File: tb/tb_sensor_spi_arbiter.sv
// tb/tb_sensor_spi_arbiter.sv - self-checking bench for sensor_spi_arbiter
module tb_sensor_spi_arbiter;

    localparam int GAP = 4;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] r_start, r_tx_valid, r_cs_n;
    logic [7:0] r_tx_data0, r_tx_data1;
    logic [1:0] r_tx_ready, r_rx_valid, r_busy;
    logic [7:0] r_rx_data;
    logic       m_start, m_tx_valid;
    logic [7:0] m_tx_data;
    logic       m_tx_ready, m_rx_valid, m_busy;
    logic [7:0] m_rx_data;
    logic [1:0] cs_n;
    logic       grant_id, grant_active, timeout_err;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    sensor_spi_arbiter #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_start      (r_start),
        .r_tx_valid   (r_tx_valid),
        .r_tx_data0   (r_tx_data0),
        .r_tx_data1   (r_tx_data1),
        .r_cs_n       (r_cs_n),
        .r_tx_ready   (r_tx_ready),
        .r_rx_valid   (r_rx_valid),
        .r_busy       (r_busy),
        .r_rx_data    (r_rx_data),
        .m_start      (m_start),
        .m_tx_valid   (m_tx_valid),
        .m_tx_data    (m_tx_data),
        .m_tx_ready   (m_tx_ready),
        .m_rx_valid   (m_rx_valid),
        .m_busy       (m_busy),
        .m_rx_data    (m_rx_data),
        .cs_n         (cs_n),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .timeout_err  (timeout_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Counts non-granted cycles until grant_active, bounded by 'bound'.
    task automatic wait_grant(input int start, input int bound, output int n);
        n = start;
        while (!grant_active && n < bound) begin
            n++;
            tick;
        end
    endtask

    initial begin
        int n;
        int ga;

        rst_n = 1'b0; r_start = 2'b00; r_tx_valid = 2'b00; r_cs_n = 2'b11;
        r_tx_data0 = 8'h00; r_tx_data1 = 8'h00;
        m_tx_ready = 1'b0; m_rx_valid = 1'b0; m_busy = 1'b0; m_rx_data = 8'h00;
        #12;
        chk("rst_cs_n", cs_n, 2'b11);
        chk("rst_r_busy", r_busy, 2'b11);
        chk("rst_grant_active", grant_active, 1'b0);
        chk("rst_grant_id", grant_id, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_m_start", m_start, 1'b0);
        chk("rst_r_rx_data", r_rx_data, 8'h00);
        tick; rst_n = 1'b1;
        tick;

        // Single request from requester 0: one-cycle grant latency.
        r_cs_n = 2'b10; exp_q.push_back(1'b0);
        #1 chk("lat_pre_cs_n", cs_n, 2'b11);
        tick;
        chk("g0_cs_n", cs_n, 2'b10);
        chk("g0_id", grant_id, exp_q.pop_front());
        chk("g0_active", grant_active, 1'b1);

        // Pass-through for the granted requester.
        r_start = 2'b01; r_tx_valid = 2'b01; r_tx_data0 = 8'hA5; r_tx_data1 = 8'h5A;
        m_tx_ready = 1'b1; m_rx_valid = 1'b1; m_rx_data = 8'h3C;
        #1;
        chk("pt_m_start", m_start, 1'b1);
        chk("pt_m_tx_valid", m_tx_valid, 1'b1);
        chk("pt_m_tx_data", m_tx_data, 8'hA5);
        chk("pt_r_tx_ready", r_tx_ready, 2'b01);
        chk("pt_r_rx_valid", r_rx_valid, 2'b01);
        chk("pt_r_rx_data", r_rx_data, 8'h3C);
        chk("pt_r_busy", r_busy, 2'b10);

        // Non-granted requester strobes are dropped.
        r_start = 2'b10; r_tx_valid = 2'b10; r_cs_n = 2'b00;
        #1;
        chk("ng_m_start", m_start, 1'b0);
        chk("ng_m_tx_valid", m_tx_valid, 1'b0);
        chk("ng_r_tx_ready", r_tx_ready, 2'b01);
        chk("ng_r_busy1", r_busy[1], 1'b1);
        tick;
        chk("ng_hold_cs_n", cs_n, 2'b10);

        // Release 0 while the master stays busy: long DRAIN.
        r_cs_n = 2'b01; m_busy = 1'b1; r_start = 2'b01; r_tx_valid = 2'b01;
        m_rx_valid = 1'b0; exp_q.push_back(1'b1);
        tick;
        chk("drain_cs_n", cs_n, 2'b11);
        chk("drain_active", grant_active, 1'b0);
        chk("drain_m_start", m_start, 1'b0);
        chk("drain_m_tx_valid", m_tx_valid, 1'b0);
        repeat (4) tick;
        chk("drain_still_cs_n", cs_n, 2'b11);
        m_busy = 1'b0; r_start = 2'b00; r_tx_valid = 2'b00;
        wait_grant(4, 50, n);
        chk("drain_hi_cycles", n, 7);
        chk("g1_id", grant_id, exp_q.pop_front());
        chk("g1_cs_n", cs_n, 2'b01);

        // Release 1, nobody requests: bus stays idle.
        r_cs_n = 2'b11;
        tick;
        chk("rel1_cs_n", cs_n, 2'b11);
        ga = 0;
        repeat (12) begin
            tick;
            if (grant_active) ga++;
        end
        chk("idle_no_grant", ga, 0);

        // Timeout: requester 0 holds for 150 cycles.
        r_cs_n = 2'b10; exp_q.push_back(1'b0);
        wait_grant(0, 10, n);
        chk("tg_id", grant_id, exp_q.pop_front());
        n = 0;
        while (cs_n[0] == 1'b0 && n < 200) begin
            n++;
            tick;
        end
        chk("tmo_len", n, TMO);
        chk("tmo_err", timeout_err, 1'b1);
        chk("tmo_cs_n", cs_n, 2'b11);
        ga = 0;
        repeat (49) begin
            tick;
            if (grant_active) ga++;
        end
        chk("tmo_blocked", ga, 0);
        r_cs_n = 2'b11;
        tick;
        r_cs_n = 2'b10; exp_q.push_back(1'b0);
        wait_grant(0, 10, n);
        chk("regrant_active", grant_active, 1'b1);
        chk("regrant_id", grant_id, exp_q.pop_front());
        chk("regrant_cs_n", cs_n, 2'b10);
        chk("regrant_err_sticky", timeout_err, 1'b1);

        // Asynchronous reset mid-GRANT.
        r_start = 2'b01;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", cs_n, 2'b11);
        chk("arst_r_busy", r_busy, 2'b11);
        chk("arst_err", timeout_err, 1'b0);
        chk("arst_active", grant_active, 1'b0);
        chk("arst_m_start", m_start, 1'b0);

        // Both request after reset: requester 0 first, then a 4-cycle gap.
        r_start = 2'b00; r_cs_n = 2'b00;
        tick;
        rst_n = 1'b1;
        #1 chk("both_pre_cs_n", cs_n, 2'b11);
        exp_q.push_back(1'b0);
        tick;
        chk("both_cs_n", cs_n, 2'b10);
        chk("both_id", grant_id, exp_q.pop_front());
        r_cs_n = 2'b01; exp_q.push_back(1'b1);
        tick;
        chk("gap_drain_cs_n", cs_n, 2'b11);
        wait_grant(0, 20, n);
        chk("gap_hi_cycles", n, GAP);
        chk("gap_g1_id", grant_id, exp_q.pop_front());
        chk("gap_g1_cs_n", cs_n, 2'b01);

        // Release in the same cycle as timeout: timeout wins.
        repeat (TMO - 1) tick;
        chk("tie_last_cs_n", cs_n, 2'b01);
        r_cs_n = 2'b11;
        tick;
        chk("tie_err", timeout_err, 1'b1);
        chk("tie_cs_n", cs_n, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
